// File: rtl/stage_execute_pkg.sv
// Shared definitions for the execute stage: operation codes, operand-select
// encodings, memory modes, exception codes and the HI/LO result function.
package stage_execute_pkg;

   localparam int ALU_OP_LEN   = 5;
   localparam int MEM_MODE_LEN = 2;
   localparam int EXC_CODE_LEN = 5;

   typedef enum logic [ALU_OP_LEN-1:0] {
      ALU_NOP = 0,
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
   } alu_op_e;

   localparam logic ALU_SRC0_RS  = 1'b0;
   localparam logic ALU_SRC0_SA  = 1'b1;
   localparam logic ALU_SRC1_RT  = 1'b0;
   localparam logic ALU_SRC1_EXT = 1'b1;

   typedef enum logic [MEM_MODE_LEN-1:0] {
      MEM_NONE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_mode_e;

   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_NONE = 5'd0;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;
   localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_OV   = 5'd12;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   function automatic logic is_md_op(input alu_op_e op);
      return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
   endfunction

   function automatic logic is_mult_op(input alu_op_e op);
      return op inside {ALU_MULT, ALU_MULTU};
   endfunction

   // {HI, LO} produced by a multiply/divide; divide by zero keeps the old pair.
   function automatic logic [63:0] md_compute(input alu_op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] hi_q,
                                              input logic [31:0] lo_q);
      logic signed [31:0] a_s;
      logic signed [31:0] b_s;
      a_s = a;
      b_s = b;
      case (op)
         ALU_MULT:  return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         ALU_MULTU: return {32'd0, a} * {32'd0, b};
         ALU_DIVU: begin
            if (b == 32'd0) return {hi_q, lo_q};
            return {a % b, a / b};
         end
         ALU_DIV: begin
            if (b == 32'd0) return {hi_q, lo_q};
            // The only signed quotient that does not fit: wraps to itself.
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(a_s % b_s), 32'(a_s / b_s)};
         end
         default:   return {hi_q, lo_q};
      endcase
   endfunction

endpackage

// File: rtl/stage_execute_md_unit.sv
// HI/LO multiply/divide unit: operand latches, busy counter, start/commit.
// Optional macro MD_ZERO_SKIP_EN: a zero mult operand or zero divisor
// commits at the start edge instead of occupying the unit.
module md_unit
   import stage_execute_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  alu_op_e     alu_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        cancel,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_busy
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   md_state_e          state, state_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [31:0]        hi_n, lo_n, a_q, a_n, b_q, b_n;
   alu_op_e            op_q, op_n;
   logic               md_req, busy_reg, start, skip;

   assign md_req   = is_md_op(alu_op);
   assign busy_reg = (state == MD_BUSY);
   assign start    = md_req && !busy_reg && !cancel && !reset;
   // A flushed md op still shows busy for its own cycle so decode never
   // issues a second md op alongside it; only the load is suppressed.
   assign md_busy  = !reset && (md_req || busy_reg);

`ifdef MD_ZERO_SKIP_EN
   assign skip = (is_mult_op(alu_op) && (rs_data == 32'd0 || rt_data == 32'd0)) ||
                 (!is_mult_op(alu_op) && rt_data == 32'd0);
`else
   assign skip = 1'b0;
`endif

   // Next-state, counter and HI/LO update selection.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch.
      state_n = state;
      count_n = count;
      hi_n    = hi;
      lo_n    = lo;
      a_n     = a_q;
      b_n     = b_q;
      op_n    = op_q;
      case (state)
         MD_IDLE: begin
            if (start) begin
               a_n  = rs_data;
               b_n  = rt_data;
               op_n = alu_op;
               if (skip) begin
                  {hi_n, lo_n} = md_compute(alu_op, rs_data, rt_data, hi, lo);
               end else begin
                  count_n = is_mult_op(alu_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state_n = MD_BUSY;
               end
            end else if (!cancel && alu_op == ALU_MTHI) begin
               hi_n = rs_data;
            end else if (!cancel && alu_op == ALU_MTLO) begin
               lo_n = rs_data;
            end
         end
         MD_BUSY: begin
            count_n = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               state_n      = MD_IDLE;
               {hi_n, lo_n} = md_compute(op_q, a_q, b_q, hi, lo);
            end
         end
         default: state_n = MD_IDLE;
      endcase
   end

   // Registers; reset clears HI/LO and abandons any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: HI/LO are architectural registers, so they are reset like any flop.
         state <= MD_IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= ALU_NOP;
      end else begin
         // NOTE: non-blocking assignments so all registers update together.
         state <= state_n;
         count <= count_n;
         hi    <= hi_n;
         lo    <= lo_n;
         a_q   <= a_n;
         b_q   <= b_n;
         op_q  <= op_n;
      end
   end

endmodule

// File: rtl/stage_execute.sv
// Execute stage: operand muxes, combinational ALU, execute-stage exceptions,
// and the HI/LO multiply/divide unit.
// Optional macro MD_ZERO_SKIP_EN is handled inside md_unit.
module stage_execute
   import stage_execute_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
)(
   input  logic                    clk,
   input  logic                    reset,
   input  alu_op_e                 alu_op,
   input  logic                    alu_src0,
   input  logic                    alu_src1,
   input  logic [4:0]              sa,
   input  logic [31:0]             rs_data,
   input  logic [31:0]             rt_data,
   input  logic [31:0]             ext_imm,
   input  logic                    check_overflow,
   input  mem_mode_e               mem_mode,
   input  logic                    cancel,
   output logic [31:0]             result,
   output logic                    md_busy,
   output logic [EXC_CODE_LEN-1:0] exc
);

   logic [31:0] op0, op1, sum, diff, hi, lo;
   logic        add_ovf, sub_ovf;

   assign op0  = (alu_src0 == ALU_SRC0_SA)  ? {27'd0, sa} : rs_data;
   assign op1  = (alu_src1 == ALU_SRC1_EXT) ? ext_imm     : rt_data;
   assign sum  = op0 + op1;
   assign diff = op0 - op1;
   // Signed overflow: result sign disagrees with operands of matching sign.
   assign add_ovf = (op0[31] == op1[31]) && (sum[31]  != op0[31]);
   assign sub_ovf = (op0[31] != op1[31]) && (diff[31] != op0[31]);

   md_unit #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md (
      .clk    (clk),
      .reset  (reset),
      .alu_op (alu_op),
      .rs_data(rs_data),
      .rt_data(rt_data),
      .cancel (cancel),
      .hi     (hi),
      .lo     (lo),
      .md_busy(md_busy)
   );

   // ALU result selection.
   always_comb begin
      result = 32'd0;
      case (alu_op)
         ALU_ADD:  result = sum;
         ALU_SUB:  result = diff;
         ALU_AND:  result = op0 & op1;
         ALU_OR:   result = op0 | op1;
         ALU_XOR:  result = op0 ^ op1;
         ALU_NOR:  result = ~(op0 | op1);
         ALU_SLL:  result = op1 << op0[4:0];
         ALU_SRL:  result = op1 >> op0[4:0];
         ALU_SRA:  result = $signed(op1) >>> op0[4:0];
         ALU_SLT:  result = {31'd0, $signed(op0) < $signed(op1)};
         ALU_SLTU: result = {31'd0, op0 < op1};
         ALU_MFHI: result = hi;
         ALU_MFLO: result = lo;
         default:  result = 32'd0;
      endcase
   end

   // Exception code; an address fault outranks arithmetic overflow.
   always_comb begin
      exc = EXC_CODE_NONE;
      if (mem_mode == MEM_READ && add_ovf)
         exc = EXC_CODE_ADEL;
      else if (mem_mode == MEM_WRITE && add_ovf)
         exc = EXC_CODE_ADES;
      else if (check_overflow && ((alu_op == ALU_ADD && add_ovf) || (alu_op == ALU_SUB && sub_ovf)))
         exc = EXC_CODE_OV;
   end

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: directed cases plus random traffic
// compared against an arithmetic reference model of the ALU and HI/LO unit.
module tb_stage_execute;
   import stage_execute_pkg::*;

   localparam int unsigned MULT_CYCLES = 5;
   localparam int unsigned DIV_CYCLES  = 10;

   logic        clk = 1'b0;
   logic        reset;
   alu_op_e     in_op;
   logic        in_src0, in_src1, in_ovc, in_cancel;
   logic [4:0]  in_sa;
   logic [31:0] in_rs, in_rt, in_imm;
   mem_mode_e   in_mm;
   logic [31:0] result;
   logic        md_busy;
   logic [4:0]  exc;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   int          m_left = 0;
   logic [31:0] last_result;
   logic [4:0]  last_exc;
   logic        last_busy;

   stage_execute #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .reset(reset), .alu_op(in_op), .alu_src0(in_src0), .alu_src1(in_src1),
      .sa(in_sa), .rs_data(in_rs), .rt_data(in_rt), .ext_imm(in_imm),
      .check_overflow(in_ovc), .mem_mode(in_mm), .cancel(in_cancel),
      .result(result), .md_busy(md_busy), .exc(exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   function automatic logic model_is_md(input alu_op_e op);
      return op == ALU_MULT || op == ALU_MULTU || op == ALU_DIV || op == ALU_DIVU;
   endfunction

   function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      int sh, sb;
      sh = int'(a & 32'd31);
      sb = b;
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLL:  return b << sh;
         ALU_SRL:  return b >> sh;
         ALU_SRA:  return sb >>> sh;
         ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_MFHI: return m_hi;
         ALU_MFLO: return m_lo;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic [4:0] ref_exc(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                          input logic ovc, input mem_mode_e mm);
      longint maxi, mini, s, d;
      int ia, ib;
      logic add_bad, sub_bad;
      maxi = 2147483647;
      mini = -maxi - 1;
      ia = a;
      ib = b;
      s = longint'(ia) + longint'(ib);
      d = longint'(ia) - longint'(ib);
      add_bad = (s > maxi) || (s < mini);
      sub_bad = (d > maxi) || (d < mini);
      if (mm == MEM_READ && add_bad)  return 5'd4;
      if (mm == MEM_WRITE && add_bad) return 5'd5;
      if (ovc && ((op == ALU_ADD && add_bad) || (op == ALU_SUB && sub_bad))) return 5'd12;
      return 5'd0;
   endfunction

   // Pending {HI,LO} for an md op from plain 64-bit arithmetic.
   task automatic ref_md(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint la, lb, p, q, r;
      longint unsigned pu;
      int ia, ib;
      ia = a;
      ib = b;
      la = ia;
      lb = ib;
      p_hi = m_hi;
      p_lo = m_lo;
      case (op)
         ALU_MULT: begin p = la * lb; p_hi = p[63:32]; p_lo = p[31:0]; end
         ALU_MULTU: begin
            pu = longint'({32'd0, a}) * longint'({32'd0, b});
            p_hi = pu[63:32];
            p_lo = pu[31:0];
         end
         ALU_DIV: if (b != 0) begin q = la / lb; r = la % lb; p_hi = r[31:0]; p_lo = q[31:0]; end
         ALU_DIVU: if (b != 0) begin p_hi = a % b; p_lo = a / b; end
         default: ;
      endcase
   endtask

   task automatic model_edge();
      logic zero_case;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (model_is_md(in_op) && !in_cancel) begin
         ref_md(in_op, in_rs, in_rt);
         zero_case = 1'b0;
`ifdef MD_ZERO_SKIP_EN
         zero_case = ((in_op == ALU_MULT || in_op == ALU_MULTU) && (in_rs == 0 || in_rt == 0)) ||
                     ((in_op == ALU_DIV || in_op == ALU_DIVU) && in_rt == 0);
`endif
         if (zero_case) begin
            m_hi = p_hi; m_lo = p_lo;
         end else begin
            m_left = (in_op == ALU_MULT || in_op == ALU_MULTU) ? MULT_CYCLES : DIV_CYCLES;
         end
      end else if (!in_cancel && in_op == ALU_MTHI) begin
         m_hi = in_rs;
      end else if (!in_cancel && in_op == ALU_MTLO) begin
         m_lo = in_rs;
      end
   endtask

   task automatic set_in(input alu_op_e op, input logic s0, input logic s1, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic ovc, input mem_mode_e mm, input logic cn);
      in_op = op; in_src0 = s0; in_src1 = s1; in_sa = sa; in_rs = rs; in_rt = rt;
      in_imm = imm; in_ovc = ovc; in_mm = mm; in_cancel = cn;
   endtask

   task automatic nop();
      set_in(ALU_NOP, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0);
   endtask

   // One clock: inputs already applied at posedge+1; compare at the falling edge.
   task automatic cycle(input string tag);
      logic [31:0] a, b;
      #4;
      a = in_src0 ? {27'd0, in_sa} : in_rs;
      b = in_src1 ? in_imm : in_rt;
      last_result = result;
      last_exc    = exc;
      last_busy   = md_busy;
      check({tag, "_result"}, result, ref_alu(in_op, a, b));
      check({tag, "_exc"}, {27'd0, exc}, {27'd0, ref_exc(in_op, a, b, in_ovc, in_mm)});
      check({tag, "_busy"}, {31'd0, md_busy},
            {31'd0, !reset && (model_is_md(in_op) || m_left != 0)});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Issue an md op, then NOPs until the model unit goes idle; count busy cycles.
   task automatic run_md(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, output int n);
      n = 0;
      set_in(op, 0, 0, 0, a, b, 0, 0, MEM_NONE, 0);
      cycle("md_start");
      n += int'(last_busy);
      nop();
      for (int i = 0; i < 40; i++) begin
         if (m_left == 0) break;
         cycle("md_wait");
         n += int'(last_busy);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0);
      cycle("reset");
      check("reset_hi", last_result, 32'h0);
      reset = 1'b0;

      // Signed overflow trap versus unchecked add
      set_in(ALU_ADD, 0, 0, 0, 32'h7FFF_FFFF, 32'd1, 0, 1, MEM_NONE, 0);
      cycle("add_ov");
      check("add_ov_code", {27'd0, last_exc}, 32'd12);
      set_in(ALU_ADD, 0, 0, 0, 32'h7FFF_FFFF, 32'd1, 0, 0, MEM_NONE, 0);
      cycle("addu");
      check("addu_value", last_result, 32'h8000_0000);
      check("addu_code", {27'd0, last_exc}, 32'd0);

      // mult -3 * 5
      run_md(ALU_MULT, -32'sd3, 32'd5, n);
      check("mult_busy_len", n, 32'd6);
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("mult_hi");
      check("mult_hi_val", last_result, 32'hFFFF_FFFF);
      set_in(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("mult_lo");
      check("mult_lo_val", last_result, 32'hFFFF_FFF1);

      // div -7 / 2
      run_md(ALU_DIV, -32'sd7, 32'd2, n);
      check("div_busy_len", n, 32'd11);
      set_in(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("div_lo");
      check("div_lo_val", last_result, 32'hFFFF_FFFD);
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("div_hi");
      check("div_hi_val", last_result, 32'hFFFF_FFFF);

      // divu by zero leaves HI/LO alone
      run_md(ALU_DIVU, 32'd7, 32'd0, n);
`ifdef MD_ZERO_SKIP_EN
      check("divz_busy_len", n, 32'd1);
`else
      check("divz_busy_len", n, 32'd11);
`endif
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("divz_hi");
      check("divz_hi_val", last_result, 32'hFFFF_FFFF);
      set_in(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("divz_lo");
      check("divz_lo_val", last_result, 32'hFFFF_FFFD);

      // Cancelled mult: busy for its own cycle only, no HI/LO change
      set_in(ALU_MULT, 0, 0, 0, 32'd9, 32'd9, 0, 0, MEM_NONE, 1);
      cycle("mult_cancel");
      check("cancel_busy_now", {31'd0, last_busy}, 32'd1);
      nop(); cycle("cancel_after");
      check("cancel_busy_next", {31'd0, last_busy}, 32'd0);
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("cancel_hi");
      check("cancel_hi_val", last_result, 32'hFFFF_FFFF);

      // mthi then mfhi
      set_in(ALU_MTHI, 0, 0, 0, 32'h1234, 0, 0, 0, MEM_NONE, 0); cycle("mthi");
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("mthi_rd");
      check("mthi_val", last_result, 32'h1234);

      // Signed quotient overflow case
      run_md(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
      set_in(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("divmin_lo");
      check("divmin_lo_val", last_result, 32'h8000_0000);
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("divmin_hi");
      check("divmin_hi_val", last_result, 32'h0);

      // Reset in the middle of a divide
      set_in(ALU_DIV, 0, 0, 0, 32'd100, 32'd7, 0, 0, MEM_NONE, 0); cycle("rdiv_start");
      nop();
      for (int i = 0; i < 3; i++) cycle("rdiv_run");
      #2 reset = 1'b1;
      #1 check("reset_async_busy", {31'd0, md_busy}, 32'd0);
      m_hi = 0; m_lo = 0; m_left = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      set_in(ALU_MFHI, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("rst_hi");
      check("rst_hi_val", last_result, 32'h0);
      set_in(ALU_MFLO, 0, 0, 0, 0, 0, 0, 0, MEM_NONE, 0); cycle("rst_lo");
      check("rst_lo_val", last_result, 32'h0);

      // Address overflow on load/store; lui via shift by 16
      set_in(ALU_ADD, 0, 1, 0, 32'h7FFF_FFFC, 0, 32'd8, 0, MEM_READ, 0); cycle("lw");
      check("lw_code", {27'd0, last_exc}, 32'd4);
      set_in(ALU_ADD, 0, 1, 0, 32'h7FFF_FFFC, 0, 32'd8, 0, MEM_WRITE, 0); cycle("sw");
      check("sw_code", {27'd0, last_exc}, 32'd5);
      set_in(ALU_SLL, 1, 1, 5'd16, 0, 0, 32'h1234, 0, MEM_NONE, 0); cycle("lui");
      check("lui_val", last_result, 32'h1234_0000);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] v[2];
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 3))
               0:       v[k] = 32'd0;
               1:       v[k] = $urandom_range(0, 20);
               2:       v[k] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
               default: v[k] = $urandom;
            endcase
         end
         set_in(alu_op_e'(5'($urandom_range(0, 19))), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom), v[0], v[1], $urandom,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? mem_mode_e'(2'($urandom_range(0, 2))) : MEM_NONE,
                $urandom_range(0, 7) == 0);
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
